// File: rtl/rom_mult_arbiter.sv
// Shares one 5x5 product ROM among NREQ requesters; grants one per cycle (round-robin or fixed priority).
// Latency: accept -> rom_en 1 cycle, accept -> rsp_valid 2+ROM_LAT cycles; one accept per cycle, in-order responses.
// Backpressure: none on responses; requesters hold req/operands until granted, rsp must always be sunk.
module rom_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int ROM_LAT = 1,
    parameter int IDXW    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pri_mode,
    input  logic [NREQ-1:0]      req,
    input  logic [5*NREQ-1:0]    req_a,
    input  logic [5*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [9:0]           rsp_data,
    output logic                 rom_en,
    output logic [4:0]           rom_a,
    output logic [4:0]           rom_b,
    input  logic [9:0]           rom_q,
    output logic                 idle
);

    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_nxt;
    logic [IDXW-1:0] sel_idx;
    logic [4:0]      sel_a;
    logic [4:0]      sel_b;
    logic            accept;
    int              start_i;
    int              j;

    // Tag pipeline: stage 0 aligns with rom_en, stage ROM_LAT aligns with rom_q.
    logic [ROM_LAT:0] tag_vld;
    logic [IDXW-1:0]  tag_idx [ROM_LAT+1];
    logic [NREQ-1:0]  rsp_onehot;

    // Arbitration: search from ptr (round-robin) or from 0 (fixed), held off while in reset.
    always_comb begin
        gnt     = '0;
        sel_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        accept  = 1'b0;
        start_i = pri_mode ? 0 : int'(ptr);
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (start_i + k) % NREQ;
            if (reset && !accept && req[j]) begin
                accept  = 1'b1;
                gnt[j]  = 1'b1;
                sel_idx = IDXW'(j);
                sel_a   = req_a[5*j +: 5];
                sel_b   = req_b[5*j +: 5];
            end
        end
        ptr_nxt = (sel_idx == IDXW'(NREQ-1)) ? '0 : sel_idx + IDXW'(1);
    end

    // Round-robin pointer moves past the winner; fixed-priority grants leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (accept && !pri_mode) begin
            ptr <= ptr_nxt;
        end
    end

    // Launch the accepted operands to the ROM; address holds when nothing is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_en <= 1'b0;
            rom_a  <= '0;
            rom_b  <= '0;
        end else begin
            rom_en <= accept;
            if (accept) begin
                rom_a <= sel_a;
                rom_b <= sel_b;
            end
        end
    end

    // Carry the requester tag alongside the ROM access; reset drops anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld <= '0;
            for (int s = 0; s <= ROM_LAT; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            tag_vld    <= {tag_vld[ROM_LAT-1:0], accept};
            tag_idx[0] <= sel_idx;
            for (int s = 1; s <= ROM_LAT; s++) begin
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    // Decode the last tag stage into a one-hot response strobe.
    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (tag_vld[ROM_LAT] && (tag_idx[ROM_LAT] == IDXW'(i))) begin
                rsp_onehot[i] = 1'b1;
            end
        end
    end

    // Register the response; data holds between responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rsp_onehot;
            if (tag_vld[ROM_LAT]) begin
                rsp_data <= rom_q;
            end
        end
    end

    // Idle when no request is pending and every stage, including the output, is empty.
    always_comb begin
        idle = !reset || ((req == '0) && (tag_vld == '0) && (rsp_valid == '0));
    end

endmodule

// File: tb/tb_rom_mult_arbiter.sv
// Self-checking bench for rom_mult_arbiter: ROM_LAT=1 instance plus a ROM_LAT=3 instance on shared inputs.
// Latency: checks sample on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: none; bench ROM models return a*b after ROM_LAT cycles.
module tb_rom_mult_arbiter;

    logic        clk;
    logic        reset;
    logic        pri_mode;
    logic [3:0]  req;
    logic [19:0] req_a;
    logic [19:0] req_b;

    logic [3:0]  gnt, rsp_valid;
    logic [9:0]  rsp_data, rom_q;
    logic        rom_en, idle;
    logic [4:0]  rom_a, rom_b;

    logic [3:0]  gnt3, rsp_valid3;
    logic [9:0]  rsp_data3, rom_q3, q3_s1, q3_s2;
    logic        rom_en3, idle3;
    logic [4:0]  rom_a3, rom_b3;

    int errors = 0;
    int checks = 0;

    rom_mult_arbiter #(.NREQ(4), .ROM_LAT(1), .IDXW(2)) dut (
        .clk(clk), .reset(reset), .pri_mode(pri_mode), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rom_en(rom_en),
        .rom_a(rom_a), .rom_b(rom_b), .rom_q(rom_q), .idle(idle)
    );

    rom_mult_arbiter #(.NREQ(4), .ROM_LAT(3), .IDXW(2)) dut3 (
        .clk(clk), .reset(reset), .pri_mode(pri_mode), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rom_en(rom_en3),
        .rom_a(rom_a3), .rom_b(rom_b3), .rom_q(rom_q3), .idle(idle3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle product ROM.
    always @(posedge clk) begin
        rom_q <= {5'd0, rom_a} * {5'd0, rom_b};
    end

    // Three-cycle product ROM.
    always @(posedge clk) begin
        q3_s1  <= {5'd0, rom_a3} * {5'd0, rom_b3};
        q3_s2  <= q3_s1;
        rom_q3 <= q3_s2;
    end

    typedef struct {
        logic [3:0] req;
        logic       pri;
        logic [3:0] gnt;
        logic       rom_en;
        logic [3:0] rsp_vld;
        logic [9:0] rsp_dat;
        logic       idle;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] r, input logic p, input logic [3:0] g, input logic en,
                       input logic [3:0] rv, input logic [9:0] rd, input logic idl);
        vec_t v;
        v.req = r; v.pri = p; v.gnt = g; v.rom_en = en; v.rsp_vld = rv; v.rsp_dat = rd; v.idle = idl;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int pulses;

    initial begin
        reset    = 1'b0;
        pri_mode = 1'b0;
        req      = 4'b1111;
        // Requester i operands: a = 3,5,7,9 ; b = 10,11,12,13 -> 30,55,84,117.
        req_a    = {5'd9, 5'd7, 5'd5, 5'd3};
        req_b    = {5'd13, 5'd12, 5'd11, 5'd10};

        //   req      pri   gnt      en    rsp_vld  data  idle
        add(4'b1111, 1'b0, 4'b0001, 1'b0, 4'b0000, 10'd0,   1'b0); // 0
        add(4'b1111, 1'b0, 4'b0010, 1'b1, 4'b0000, 10'd0,   1'b0); // 1
        add(4'b1111, 1'b0, 4'b0100, 1'b1, 4'b0000, 10'd0,   1'b0); // 2
        add(4'b1111, 1'b0, 4'b1000, 1'b1, 4'b0001, 10'd30,  1'b0); // 3
        add(4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0010, 10'd55,  1'b0); // 4
        add(4'b1111, 1'b0, 4'b0010, 1'b1, 4'b0100, 10'd84,  1'b0); // 5
        add(4'b1111, 1'b0, 4'b0100, 1'b1, 4'b1000, 10'd117, 1'b0); // 6
        add(4'b1111, 1'b0, 4'b1000, 1'b1, 4'b0001, 10'd30,  1'b0); // 7
        add(4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0010, 10'd55,  1'b0); // 8
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 10'd84,  1'b0); // 9
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b1000, 10'd117, 1'b0); // 10
        add(4'b1010, 1'b1, 4'b0010, 1'b0, 4'b0000, 10'd0,   1'b0); // 11 fixed priority
        add(4'b1010, 1'b1, 4'b0010, 1'b1, 4'b0000, 10'd0,   1'b0); // 12
        add(4'b1000, 1'b1, 4'b1000, 1'b1, 4'b0000, 10'd0,   1'b0); // 13 req[1] dropped
        add(4'b1010, 1'b1, 4'b0010, 1'b1, 4'b0010, 10'd55,  1'b0); // 14
        add(4'b1010, 1'b0, 4'b0010, 1'b1, 4'b0010, 10'd55,  1'b0); // 15 back to RR, ptr still 0
        add(4'b1010, 1'b0, 4'b1000, 1'b1, 4'b1000, 10'd117, 1'b0); // 16 ptr=2 -> idx 3
        add(4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0010, 10'd55,  1'b0); // 17
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010, 10'd55,  1'b0); // 18
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b1000, 10'd117, 1'b0); // 19
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 10'd0,   1'b1); // 20

        // Reset held with all requests high.
        for (int c = 0; c < 3; c++) begin
            sample();
            check("reset gnt", 32'(gnt), 32'd0);
            check("reset rom_en", 32'(rom_en), 32'd0);
            check("reset rsp_valid", 32'(rsp_valid), 32'd0);
            check("reset idle", 32'(idle), 32'd1);
            next_cycle();
        end
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset rom_a", 32'(rom_a), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            req      = tbl[i].req;
            pri_mode = tbl[i].pri;
            sample();
            check($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("row%0d rom_en", i), 32'(rom_en), 32'(tbl[i].rom_en));
            check($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rsp_vld));
            check($sformatf("row%0d idle", i), 32'(idle), 32'(tbl[i].idle));
            if (tbl[i].rsp_vld != 4'b0000)
                check($sformatf("row%0d rsp_data", i), 32'(rsp_data), 32'(tbl[i].rsp_dat));
            next_cycle();
        end

        // Drain anything left in the ROM_LAT=3 instance.
        req = 4'b0000;
        pri_mode = 1'b0;
        repeat (4) next_cycle();

        // Single request from requester 2: 13*7 = 91.
        req_a = '0; req_b = '0;
        req_a[14:10] = 5'd13;
        req_b[14:10] = 5'd7;
        req = 4'b0100;
        sample();
        check("single gnt c0", 32'(gnt), 32'b0100);
        next_cycle();
        req = 4'b0000;
        sample();
        check("single rom_en c1", 32'(rom_en), 32'd1);
        check("single rom_a c1", 32'(rom_a), 32'd13);
        check("single rom_b c1", 32'(rom_b), 32'd7);
        check("lat3 rom_en c1", 32'(rom_en3), 32'd1);
        next_cycle();
        sample();
        check("single rsp_valid c2", 32'(rsp_valid), 32'd0);
        next_cycle();
        sample();
        check("single rsp_valid c3", 32'(rsp_valid), 32'b0100);
        check("single rsp_data c3", 32'(rsp_data), 32'd91);
        check("lat3 rsp_valid c3", 32'(rsp_valid3), 32'd0);
        next_cycle();
        sample();
        check("single idle c4", 32'(idle), 32'd1);
        check("single rsp_valid c4", 32'(rsp_valid), 32'd0);
        check("lat3 rsp_valid c4", 32'(rsp_valid3), 32'd0);
        next_cycle();
        sample();
        check("lat3 rsp_valid c5", 32'(rsp_valid3), 32'b0100);
        check("lat3 rsp_data c5", 32'(rsp_data3), 32'd91);
        next_cycle();

        // Back-to-back from requester 0 with extreme operands.
        req = 4'b0001;
        req_a[4:0] = 5'd31; req_b[4:0] = 5'd31;
        sample();
        check("b2b gnt c0", 32'(gnt), 32'b0001);
        next_cycle();
        req_a[4:0] = 5'd0; req_b[4:0] = 5'd31;
        sample();
        check("b2b gnt c1", 32'(gnt), 32'b0001);
        check("b2b rom_a c1", 32'(rom_a), 32'd31);
        next_cycle();
        req_a[4:0] = 5'd1; req_b[4:0] = 5'd1;
        sample();
        check("b2b gnt c2", 32'(gnt), 32'b0001);
        next_cycle();
        req = 4'b0000;
        sample();
        check("b2b rsp_valid c3", 32'(rsp_valid), 32'b0001);
        check("b2b rsp_data c3", 32'(rsp_data), 32'd961);
        next_cycle();
        sample();
        check("b2b rsp_valid c4", 32'(rsp_valid), 32'b0001);
        check("b2b rsp_data c4", 32'(rsp_data), 32'd0);
        check("b2b rom_en c4", 32'(rom_en), 32'd0);
        check("b2b rom_a hold c4", 32'(rom_a), 32'd1);
        next_cycle();
        sample();
        check("b2b rsp_valid c5", 32'(rsp_valid), 32'b0001);
        check("b2b rsp_data c5", 32'(rsp_data), 32'd1);
        next_cycle();
        sample();
        check("b2b rsp_valid c6", 32'(rsp_valid), 32'd0);
        check("b2b rsp_data hold c6", 32'(rsp_data), 32'd1);
        repeat (4) next_cycle();

        // Reset while two accesses are in flight.
        req_a[9:0] = {5'd4, 5'd2};
        req_b[9:0] = {5'd5, 5'd3};
        req = 4'b0011;
        sample();
        check("flight gnt c0", 32'(gnt), 32'b0010);
        next_cycle();
        sample();
        check("flight gnt c1", 32'(gnt), 32'b0001);
        next_cycle();
        reset = 1'b0;
        #1;
        check("flight rom_en", 32'(rom_en), 32'd0);
        check("flight rom_a", 32'(rom_a), 32'd0);
        check("flight rom_b", 32'(rom_b), 32'd0);
        check("flight rsp_data", 32'(rsp_data), 32'd0);
        check("flight rsp_valid", 32'(rsp_valid), 32'd0);
        check("flight gnt", 32'(gnt), 32'd0);
        check("flight idle", 32'(idle), 32'd1);
        req = 4'b0000;
        repeat (2) next_cycle();
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (rsp_valid != 4'b0000 || rsp_valid3 != 4'b0000) pulses++;
            next_cycle();
        end
        check("flight stray pulses", 32'(pulses), 32'd0);
        sample();
        check("flight idle after", 32'(idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
